// File: rtl/snn_pkg.sv
// Shared types and encodings for the SNN fetch path: request/packet type codes,
// sequencer state encoding and the PE-array packet bundle.
package snn_pkg;

   localparam logic [1:0] REQ_SPIKE  = 2'd1;
   localparam logic [1:0] REQ_FILTER = 2'd2;

   localparam logic PKT_WEIGHT = 1'b0;
   localparam logic PKT_SPIKE  = 1'b1;

   localparam int unsigned SNN_CW = 8;
   localparam int unsigned SNN_DW = 8;

   typedef enum logic [3:0] {
      StIdle,
      StFReq,
      StFRsp,
      StFPkt,
      StSReq,
      StSRsp,
      StSPkt,
      StWaitTs,
      StTAdv,
      StDone
   } state_e;

   // Bundle widths are the package defaults; the top casts to its own CW/F_WIDTH.
   typedef struct packed {
      logic              ptype;
      logic [SNN_CW-1:0] x;
      logic [SNN_CW-1:0] y;
      logic [SNN_DW-1:0] data;
   } pkt_t;

endpackage

// File: rtl/snn_raster_counter.sv
// Row-major 2-D counter with run-time bounds; wraps to (0,0) when stepped on the
// last position so one instance can serve both the filter and spike-map scans.
module snn_raster_counter #(
   parameter int unsigned CW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          step,
   input  logic [CW-1:0] rows,
   input  logic [CW-1:0] cols,
   output logic [CW-1:0] row,
   output logic [CW-1:0] col,
   output logic          last
);

   logic [CW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          col_end;

   always_comb begin
      col_end = (col_q == cols - CW'(1));
      last    = col_end && (row_q == rows - CW'(1));
      row_d   = row_q;
      col_d   = col_q;
      if (clear) begin
         row_d = '0;
         col_d = '0;
      end else if (step) begin
         if (last) begin
            row_d = '0;
            col_d = '0;
         end else if (col_end) begin
            row_d = row_q + CW'(1);
            col_d = '0;
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row = row_q;
   assign col = col_q;

endmodule

// File: rtl/snn_load_sequencer.sv
// Fetch sequencer: loads all filter weights once per run, then per timestep scans
// the input-spike map forwarding only set spikes, and advances the memory timestep.
module snn_load_sequencer
   import snn_pkg::*;
#(
   parameter int unsigned TIMESTEPS = 10,
   parameter int unsigned F_ROWS    = 3,
   parameter int unsigned F_COLS    = 3,
   parameter int unsigned F_WIDTH   = SNN_DW,
   parameter int unsigned IF_ROWS   = 5,
   parameter int unsigned IF_COLS   = 5,
   parameter int unsigned CW        = SNN_CW
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               req_valid,
   input  logic               req_ready,
   output logic [1:0]         req_type,
   output logic [CW-1:0]      req_x,
   output logic [CW-1:0]      req_y,
   input  logic               rsp_valid,
   input  logic [F_WIDTH-1:0] rsp_data,
   output logic               pkt_valid,
   input  logic               pkt_ready,
   output logic               pkt_type,
   output logic [CW-1:0]      pkt_x,
   output logic [CW-1:0]      pkt_y,
   output logic [F_WIDTH-1:0] pkt_data,
   input  logic               ts_done,
   output logic               t_valid,
   output logic [CW-1:0]      t_value,
   output logic               busy,
   output logic               done
);

   state_e             state_q, state_d;
   logic [F_WIDTH-1:0] weight_q, weight_d;
   logic [CW-1:0]      t_q, t_d;
   logic               cnt_clear, cnt_step, cnt_last;
   logic [CW-1:0]      cnt_rows, cnt_cols, row, col;
   logic               filter_phase;
   pkt_t               pkt;

   // The single counter is retargeted by phase: filter bounds until the scan begins.
   assign filter_phase = (state_q == StFReq) || (state_q == StFRsp) || (state_q == StFPkt);
   assign cnt_rows     = filter_phase ? CW'(F_ROWS) : CW'(IF_ROWS);
   assign cnt_cols     = filter_phase ? CW'(F_COLS) : CW'(IF_COLS);

   snn_raster_counter #(
      .CW(CW)
   ) u_counter (
      .clk  (clk),
      .reset(reset),
      .clear(cnt_clear),
      .step (cnt_step),
      .rows (cnt_rows),
      .cols (cnt_cols),
      .row  (row),
      .col  (col),
      .last (cnt_last)
   );

   always_comb begin
      state_d   = state_q;
      weight_d  = weight_q;
      t_d       = t_q;
      cnt_clear = 1'b0;
      cnt_step  = 1'b0;
      req_valid = 1'b0;
      req_type  = '0;
      req_x     = '0;
      req_y     = '0;
      pkt_valid = 1'b0;
      pkt       = '0;
      t_valid   = 1'b0;
      t_value   = '0;

      unique case (state_q)
         StIdle: begin
            cnt_clear = 1'b1;
            t_d       = '0;
            if (start) state_d = StFReq;
         end
         StFReq: begin
            req_valid = 1'b1;
            req_type  = REQ_FILTER;
            req_x     = row;
            req_y     = col;
            if (req_ready) state_d = StFRsp;
         end
         StFRsp: begin
            if (rsp_valid) begin
               weight_d = rsp_data;
               state_d  = StFPkt;
            end
         end
         StFPkt: begin
            pkt_valid = 1'b1;
            pkt.ptype = PKT_WEIGHT;
            pkt.x     = SNN_CW'(row);
            pkt.y     = SNN_CW'(col);
            pkt.data  = SNN_DW'(weight_q);
            if (pkt_ready) begin
               if (cnt_last) begin
                  cnt_clear = 1'b1;
                  state_d   = StSReq;
               end else begin
                  cnt_step = 1'b1;
                  state_d  = StFReq;
               end
            end
         end
         StSReq: begin
            req_valid = 1'b1;
            req_type  = REQ_SPIKE;
            req_x     = row;
            req_y     = col;
            if (req_ready) state_d = StSRsp;
         end
         StSRsp: begin
            if (rsp_valid) begin
               if (rsp_data[0]) begin
                  state_d = StSPkt;
               end else if (cnt_last) begin
                  cnt_clear = 1'b1;
                  state_d   = StWaitTs;
               end else begin
                  cnt_step = 1'b1;
                  state_d  = StSReq;
               end
            end
         end
         StSPkt: begin
            pkt_valid = 1'b1;
            pkt.ptype = PKT_SPIKE;
            pkt.x     = SNN_CW'(row);
            pkt.y     = SNN_CW'(col);
            pkt.data  = SNN_DW'(1);
            if (pkt_ready) begin
               if (cnt_last) begin
                  cnt_clear = 1'b1;
                  state_d   = StWaitTs;
               end else begin
                  cnt_step = 1'b1;
                  state_d  = StSReq;
               end
            end
         end
         StWaitTs: begin
            if (ts_done) state_d = StTAdv;
         end
         StTAdv: begin
            t_valid   = 1'b1;
            t_value   = t_q + CW'(1);
            t_d       = t_value;
            cnt_clear = 1'b1;
            state_d   = (t_value == CW'(TIMESTEPS)) ? StDone : StSReq;
         end
         StDone: begin
            if (start) begin
               cnt_clear = 1'b1;
               t_d       = '0;
               state_d   = StFReq;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         weight_q <= '0;
         t_q      <= '0;
      end else begin
         state_q  <= state_d;
         weight_q <= weight_d;
         t_q      <= t_d;
      end
   end

   assign pkt_type = pkt.ptype;
   assign pkt_x    = CW'(pkt.x);
   assign pkt_y    = CW'(pkt.y);
   assign pkt_data = F_WIDTH'(pkt.data);
   assign busy     = (state_q != StIdle) && (state_q != StDone);
   assign done     = (state_q == StDone);

endmodule

// File: tb/tb_snn_load_sequencer.sv
// Bench for snn_load_sequencer: acts as the memory and the PE array, and checks the
// observed request/packet/timestep streams against queues built from the spike maps.
module tb_snn_load_sequencer;

   localparam int unsigned TS = 10;
   localparam int unsigned FR = 3;
   localparam int unsigned FC = 3;
   localparam int unsigned IR = 5;
   localparam int unsigned IC = 5;

   logic       clk = 1'b0;
   logic       reset, start, req_ready, rsp_valid, pkt_ready, ts_done;
   logic [7:0] rsp_data;
   logic       req_valid;
   logic [1:0] req_type;
   logic [7:0] req_x, req_y;
   logic       pkt_valid, pkt_type;
   logic [7:0] pkt_x, pkt_y, pkt_data;
   logic       t_valid;
   logic [7:0] t_value;
   logic       busy, done;

   always #5 clk = ~clk;

   snn_load_sequencer #(
      .TIMESTEPS(TS),
      .F_ROWS   (FR),
      .F_COLS   (FC),
      .F_WIDTH  (8),
      .IF_ROWS  (IR),
      .IF_COLS  (IC),
      .CW       (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_type (req_type),
      .req_x    (req_x),
      .req_y    (req_y),
      .rsp_valid(rsp_valid),
      .rsp_data (rsp_data),
      .pkt_valid(pkt_valid),
      .pkt_ready(pkt_ready),
      .pkt_type (pkt_type),
      .pkt_x    (pkt_x),
      .pkt_y    (pkt_y),
      .pkt_data (pkt_data),
      .ts_done  (ts_done),
      .t_valid  (t_valid),
      .t_value  (t_value),
      .busy     (busy),
      .done     (done)
   );

   typedef struct {logic [1:0] typ; logic [7:0] x; logic [7:0] y;} req_s;
   typedef struct {logic typ; logic [7:0] x; logic [7:0] y; logic [7:0] data;} pkt_s;

   req_s       exp_req[$];
   pkt_s       exp_pkt[$];
   logic [7:0] weights[FR][FC];
   bit         spikes[TS][IR][IC];

   int   checks = 0;
   int   errors = 0;
   int   mem_t, exp_t;
   bit   exp_busy, exp_done, owed, ts_sent, start_req, bp;
   bit   req_hold, pkt_hold;
   req_s owed_req, req_last;
   pkt_s pkt_last;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_timestep(input int t);
      for (int r = 0; r < IR; r++)
         for (int c = 0; c < IC; c++) begin
            exp_req.push_back('{2'd1, 8'(r), 8'(c)});
            if (spikes[t][r][c]) exp_pkt.push_back('{1'b1, 8'(r), 8'(c), 8'd1});
         end
   endtask

   function automatic logic [7:0] mem_read(input req_s r);
      logic [7:0] v;
      v = 8'($urandom);
      if (r.typ == 2'd2 && r.x < FR && r.y < FC) v = weights[r.x][r.y];
      else if (r.typ == 2'd1 && r.x < IR && r.y < IC && mem_t < TS)
         v[0] = spikes[mem_t][r.x][r.y];
      return v;
   endfunction

   task automatic prepare_run(input bit directed);
      for (int r = 0; r < FR; r++)
         for (int c = 0; c < FC; c++)
            weights[r][c] = directed ? 8'(r * FC + c + 1) : 8'($urandom);
      for (int t = 0; t < TS; t++)
         for (int r = 0; r < IR; r++)
            for (int c = 0; c < IC; c++)
               spikes[t][r][c] = ($urandom_range(0, 9) < 3);
      if (directed) begin
         for (int r = 0; r < IR; r++)
            for (int c = 0; c < IC; c++) spikes[0][r][c] = 1'b0;
         spikes[0][1][2] = 1'b1;
         spikes[0][4][4] = 1'b1;
      end
      spikes[3][2][2] = 1'b1;
      exp_req.delete();
      exp_pkt.delete();
      for (int r = 0; r < FR; r++)
         for (int c = 0; c < FC; c++) begin
            exp_req.push_back('{2'd2, 8'(r), 8'(c)});
            exp_pkt.push_back('{1'b0, 8'(r), 8'(c), weights[r][c]});
         end
      push_timestep(0);
      mem_t     = 0;
      exp_t     = 1;
      owed      = 0;
      ts_sent   = 0;
      req_hold  = 0;
      pkt_hold  = 0;
      start_req = 1;
   endtask

   task automatic cycle();
      req_s er;
      pkt_s ep;
      @(negedge clk);
      if (!exp_busy) begin
         check("idle_req_valid", req_valid, 0);
         check("idle_pkt_valid", pkt_valid, 0);
      end
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      if (t_valid) begin
         check("t_value", t_value, exp_t);
         exp_t++;
         mem_t   = int'(t_value);
         ts_sent = 0;
         if (mem_t < TS) push_timestep(mem_t);
         else begin
            exp_busy = 0;
            exp_done = 1;
         end
      end
      if (req_hold) begin
         check("req_hold_valid", req_valid, 1);
         check("req_hold_type", req_type, req_last.typ);
         check("req_hold_x", req_x, req_last.x);
         check("req_hold_y", req_y, req_last.y);
      end
      if (pkt_hold) begin
         check("pkt_hold_valid", pkt_valid, 1);
         check("pkt_hold_type", pkt_type, pkt_last.typ);
         check("pkt_hold_x", pkt_x, pkt_last.x);
         check("pkt_hold_y", pkt_y, pkt_last.y);
         check("pkt_hold_data", pkt_data, pkt_last.data);
      end

      // Timestep completion is judged from work already transferred before this edge.
      ts_done = 1'b0;
      if (exp_busy && !ts_sent) begin
         if (exp_req.size() == 0 && exp_pkt.size() == 0 && !owed) begin
            if (!bp || $urandom_range(0, 1) == 1) begin
               ts_done = 1'b1;
               ts_sent = 1;
            end
         end else if (bp && $urandom_range(0, 15) == 0) begin
            ts_done = 1'b1;
         end
      end

      rsp_valid = 1'b0;
      rsp_data  = 8'($urandom);
      if (owed) begin
         if (!bp || $urandom_range(0, 2) == 0) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_read(owed_req);
            owed      = 0;
         end
      end else if (bp && $urandom_range(0, 15) == 0) begin
         rsp_valid = 1'b1;
      end

      req_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      req_hold  = 0;
      if (req_valid === 1'b1) begin
         if (req_ready) begin
            if (exp_req.size() == 0) check("req_unexpected", req_valid, 0);
            else begin
               er = exp_req.pop_front();
               check("req_type", req_type, er.typ);
               check("req_x", req_x, er.x);
               check("req_y", req_y, er.y);
            end
            owed     = 1;
            owed_req = '{req_type, req_x, req_y};
         end else begin
            req_hold = 1;
            req_last = '{req_type, req_x, req_y};
         end
      end

      pkt_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      pkt_hold  = 0;
      if (pkt_valid === 1'b1) begin
         if (pkt_ready) begin
            if (exp_pkt.size() == 0) check("pkt_unexpected", pkt_valid, 0);
            else begin
               ep = exp_pkt.pop_front();
               check("pkt_type", pkt_type, ep.typ);
               check("pkt_x", pkt_x, ep.x);
               check("pkt_y", pkt_y, ep.y);
               check("pkt_data", pkt_data, ep.data);
            end
         end else begin
            pkt_hold = 1;
            pkt_last = '{pkt_type, pkt_x, pkt_y, pkt_data};
         end
      end

      start = start_req || (bp && exp_busy && $urandom_range(0, 31) == 0);
      if (start_req) begin
         exp_busy  = 1;
         exp_done  = 0;
         start_req = 0;
      end
   endtask

   task automatic run_to_done(input string tag);
      int n = 0;
      do begin
         cycle();
         n++;
      end while (!exp_done && n < 8000);
      repeat (4) cycle();
      check({tag, "_done"}, done, 1);
      check({tag, "_req_left"}, exp_req.size(), 0);
      check({tag, "_pkt_left"}, exp_pkt.size(), 0);
      check({tag, "_t_count"}, exp_t, TS + 1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_req_valid"}, req_valid, 0);
      check({tag, "_req_type"}, req_type, 0);
      check({tag, "_req_xy"}, {req_x, req_y}, 0);
      check({tag, "_pkt_valid"}, pkt_valid, 0);
      check({tag, "_pkt_type"}, pkt_type, 0);
      check({tag, "_pkt_xyd"}, {pkt_x, pkt_y, pkt_data}, 0);
      check({tag, "_t"}, {t_valid, t_value}, 0);
      check({tag, "_busy_done"}, {busy, done}, 0);
   endtask

   initial begin
      int n;
      reset     = 1'b1;
      start     = 1'b0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_data  = '0;
      pkt_ready = 1'b0;
      ts_done   = 1'b0;
      exp_busy  = 0;
      exp_done  = 0;
      owed      = 0;
      req_hold  = 0;
      pkt_hold  = 0;
      ts_sent   = 0;
      start_req = 0;
      bp        = 0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;
      repeat (3) cycle();

      // Directed filter weights 1..9 and sparse timestep 0, full readiness.
      prepare_run(1);
      run_to_done("run1");

      // Random maps with back-pressure and stray inputs, restarted from DONE.
      bp = 1;
      prepare_run(0);
      run_to_done("run2");

      // Reset while a spike packet is pending in timestep 3.
      prepare_run(0);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!(mem_t == 3 && pkt_valid === 1'b1 && pkt_type === 1'b1) && n < 8000);
      check("reset_point", {30'd0, pkt_valid, pkt_type}, 3);
      reset     = 1'b1;
      start     = 1'b0;
      ts_done   = 1'b0;
      rsp_valid = 1'b0;
      @(negedge clk);
      check_zero("midrun_reset");
      reset = 1'b0;
      exp_req.delete();
      exp_pkt.delete();
      exp_busy = 0;
      exp_done = 0;
      owed     = 0;
      req_hold = 0;
      pkt_hold = 0;
      ts_sent  = 0;
      repeat (5) cycle();

      prepare_run(0);
      run_to_done("run4");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
